// File: rtl/count_run_controller.sv
// count_run_controller
// Owns a WIDTH-bit up/down counter and sequences it through bounded runs.
// A run command (start, end, direction) is accepted over a valid/ready
// handshake while idle. The counter is then stepped once per clock until it
// reaches the end value, travelling in the commanded direction and wrapping
// modulo 2^WIDTH when needed. Completion, abort and wrap-around are reported
// as one-cycle registered pulses.

module count_run_controller #(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [WIDTH-1:0] CMD_START,
   input  logic [WIDTH-1:0] CMD_END,
   input  logic             CMD_UP,
   input  logic             PAUSE,
   input  logic             ABORT,
   output logic [WIDTH-1:0] Q,
   output logic             UP_DOWN,
   output logic             BUSY,
   output logic             DONE,
   output logic             ABORTED,
   output logic             WRAP
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_COUNT = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] end_value;
   logic [WIDTH-1:0] end_value_next;
   logic [WIDTH-1:0] q_next;
   logic             up_down_next;
   logic             busy_next;
   logic             done_next;
   logic             aborted_next;
   logic             wrap_next;
   logic             handshake;
   logic             at_end;
   logic             will_wrap;
   logic [WIDTH-1:0] stepped;

   // A command is only taken from IDLE, and never in a cycle where reset wins.
   always_comb begin
      CMD_READY = (state == IDLE) && !RESET;
      handshake = CMD_VALID && CMD_READY;
   end

   // The candidate next count and its wrap condition, for the latched direction.
   always_comb begin
      at_end = (Q == end_value);
      if (UP_DOWN) begin
         stepped   = Q + ONE;
         will_wrap = (Q == MAX_COUNT);
      end else begin
         stepped   = Q - ONE;
         will_wrap = (Q == MIN_COUNT);
      end
   end

   // Next-state and next-output decisions; pulse outputs default low each cycle.
   always_comb begin
      state_next     = state;
      q_next         = Q;
      end_value_next = end_value;
      up_down_next   = UP_DOWN;
      busy_next      = BUSY;
      done_next      = 1'b0;
      aborted_next   = 1'b0;
      wrap_next      = 1'b0;

      case (state)
         IDLE: begin
            if (handshake) begin
               q_next         = CMD_START;
               end_value_next = CMD_END;
               up_down_next   = CMD_UP;
               busy_next      = 1'b1;
               state_next     = RUN;
            end
         end

         RUN: begin
            if (ABORT) begin
               state_next   = IDLE;
               busy_next    = 1'b0;
               aborted_next = 1'b1;
            end else if (PAUSE) begin
               state_next = RUN;
            end else if (at_end) begin
               state_next = FINISH;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               q_next    = stepped;
               wrap_next = will_wrap;
            end
         end

         FINISH: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   // State and output registers, with synchronous reset taking priority.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         Q         <= MIN_COUNT;
         end_value <= MIN_COUNT;
         UP_DOWN   <= 1'b1;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ABORTED   <= 1'b0;
         WRAP      <= 1'b0;
      end else begin
         state     <= state_next;
         Q         <= q_next;
         end_value <= end_value_next;
         UP_DOWN   <= up_down_next;
         BUSY      <= busy_next;
         DONE      <= done_next;
         ABORTED   <= aborted_next;
         WRAP      <= wrap_next;
      end
   end

endmodule

// File: tb/tb_count_run_controller.sv
// tb_count_run_controller
// Directed bench for count_run_controller at WIDTH=5. Inputs change on the
// falling edge and outputs are sampled on the falling edge, half a period
// away from the rising edge the design acts on.

module tb_count_run_controller;

   localparam int W = 5;

   logic         CLK;
   logic         RESET;
   logic         CMD_VALID;
   logic         CMD_READY;
   logic [W-1:0] CMD_START;
   logic [W-1:0] CMD_END;
   logic         CMD_UP;
   logic         PAUSE;
   logic         ABORT;
   logic [W-1:0] Q;
   logic         UP_DOWN;
   logic         BUSY;
   logic         DONE;
   logic         ABORTED;
   logic         WRAP;

   int errors = 0;
   int checks = 0;

   count_run_controller #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .CMD_VALID (CMD_VALID),
      .CMD_READY (CMD_READY),
      .CMD_START (CMD_START),
      .CMD_END   (CMD_END),
      .CMD_UP    (CMD_UP),
      .PAUSE     (PAUSE),
      .ABORT     (ABORT),
      .Q         (Q),
      .UP_DOWN   (UP_DOWN),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ABORTED   (ABORTED),
      .WRAP      (WRAP)
   );

   // Free-running clock, period 10.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance one full cycle, ending on the falling edge.
   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Present one command for a single rising edge, then withdraw it.
   task automatic send_cmd(input logic [W-1:0] s, input logic [W-1:0] e, input logic up);
      CMD_VALID = 1'b1;
      CMD_START = s;
      CMD_END   = e;
      CMD_UP    = up;
      tick();
      CMD_VALID = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      tick();
      tick();
      checks++; if (CMD_READY !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_low: got %b expected 0", CMD_READY); end
      checks++; if (Q !== 5'd0) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", Q); end
      checks++; if (UP_DOWN !== 1'b1) begin errors++; $display("[TB] FAIL reset_updown: got %b expected 1", UP_DOWN); end
      checks++; if ({BUSY, DONE, ABORTED, WRAP} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {BUSY, DONE, ABORTED, WRAP}); end
      RESET = 1'b0;
      #1;
      checks++; if (CMD_READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_high: got %b expected 1", CMD_READY); end
   endtask

   task automatic test_basic_up;
      logic [W-1:0] exp_q [5] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
      send_cmd(5'd3, 5'd7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         checks++; if (Q !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_q[%0d]: got %0d expected %0d", i, Q, exp_q[i]); end
         checks++; if ({BUSY, DONE, CMD_READY} !== 3'b100) begin errors++; $display("[TB] FAIL basic_flags[%0d]: got %b expected 100", i, {BUSY, DONE, CMD_READY}); end
      end
      tick();
      checks++; if ({BUSY, DONE, CMD_READY, WRAP} !== 4'b0100) begin errors++; $display("[TB] FAIL basic_done: got %b expected 0100", {BUSY, DONE, CMD_READY, WRAP}); end
      checks++; if (Q !== 5'd7) begin errors++; $display("[TB] FAIL basic_hold_finish: got %0d expected 7", Q); end
      tick();
      checks++; if ({DONE, CMD_READY} !== 2'b01) begin errors++; $display("[TB] FAIL basic_idle: got %b expected 01", {DONE, CMD_READY}); end
      checks++; if (Q !== 5'd7) begin errors++; $display("[TB] FAIL basic_hold_idle: got %0d expected 7", Q); end
   endtask

   task automatic test_wrap_up;
      logic [W-1:0] exp_q [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
      logic         exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      send_cmd(5'd30, 5'd1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         checks++; if (Q !== exp_q[i]) begin errors++; $display("[TB] FAIL wrapup_q[%0d]: got %0d expected %0d", i, Q, exp_q[i]); end
         checks++; if (WRAP !== exp_w[i]) begin errors++; $display("[TB] FAIL wrapup_wrap[%0d]: got %b expected %b", i, WRAP, exp_w[i]); end
      end
      tick();
      checks++; if ({DONE, WRAP, Q} !== {2'b10, 5'd1}) begin errors++; $display("[TB] FAIL wrapup_done: got %b/%b/%0d expected 1/0/1", DONE, WRAP, Q); end
      tick();
   endtask

   task automatic test_wrap_down;
      logic [W-1:0] exp_q [6] = '{5'd2, 5'd1, 5'd0, 5'd31, 5'd30, 5'd29};
      logic         exp_w [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      send_cmd(5'd2, 5'd29, 1'b0);
      checks++; if (UP_DOWN !== 1'b0) begin errors++; $display("[TB] FAIL wrapdn_dir: got %b expected 0", UP_DOWN); end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         checks++; if (Q !== exp_q[i]) begin errors++; $display("[TB] FAIL wrapdn_q[%0d]: got %0d expected %0d", i, Q, exp_q[i]); end
         checks++; if (WRAP !== exp_w[i]) begin errors++; $display("[TB] FAIL wrapdn_wrap[%0d]: got %b expected %b", i, WRAP, exp_w[i]); end
      end
      tick();
      checks++; if ({DONE, Q} !== {1'b1, 5'd29}) begin errors++; $display("[TB] FAIL wrapdn_done: got %b/%0d expected 1/29", DONE, Q); end
      tick();
      checks++; if (UP_DOWN !== 1'b0) begin errors++; $display("[TB] FAIL wrapdn_dir_kept: got %b expected 0", UP_DOWN); end
   endtask

   task automatic test_pause;
      send_cmd(5'd10, 5'd15, 1'b1);
      tick();
      tick();
      checks++; if (Q !== 5'd12) begin errors++; $display("[TB] FAIL pause_pre: got %0d expected 12", Q); end
      PAUSE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({Q, BUSY, DONE} !== {5'd12, 2'b10}) begin errors++; $display("[TB] FAIL pause_hold[%0d]: got %0d/%b/%b expected 12/1/0", i, Q, BUSY, DONE); end
      end
      PAUSE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (Q !== 5'(13 + i)) begin errors++; $display("[TB] FAIL pause_resume[%0d]: got %0d expected %0d", i, Q, 13 + i); end
      end
      PAUSE = 1'b1;
      tick();
      checks++; if ({Q, DONE, BUSY} !== {5'd15, 2'b01}) begin errors++; $display("[TB] FAIL pause_at_end: got %0d/%b/%b expected 15/0/1", Q, DONE, BUSY); end
      PAUSE = 1'b0;
      tick();
      checks++; if ({DONE, BUSY} !== 2'b10) begin errors++; $display("[TB] FAIL pause_done: got %b expected 10", {DONE, BUSY}); end
      tick();
   endtask

   task automatic test_abort;
      send_cmd(5'd5, 5'd20, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      checks++; if (Q !== 5'd9) begin errors++; $display("[TB] FAIL abort_pre: got %0d expected 9", Q); end
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      checks++; if ({ABORTED, DONE, BUSY, CMD_READY} !== 4'b1001) begin errors++; $display("[TB] FAIL abort_pulse: got %b expected 1001", {ABORTED, DONE, BUSY, CMD_READY}); end
      checks++; if (Q !== 5'd9) begin errors++; $display("[TB] FAIL abort_hold: got %0d expected 9", Q); end
      tick();
      checks++; if ({ABORTED, DONE, Q} !== {2'b00, 5'd9}) begin errors++; $display("[TB] FAIL abort_after: got %b/%b/%0d expected 0/0/9", ABORTED, DONE, Q); end
      ABORT = 1'b1;
      PAUSE = 1'b1;
      tick();
      ABORT = 1'b0;
      PAUSE = 1'b0;
      checks++; if ({ABORTED, BUSY, CMD_READY, Q} !== {3'b001, 5'd9}) begin errors++; $display("[TB] FAIL abort_idle: got %b%b%b/%0d expected 001/9", ABORTED, BUSY, CMD_READY, Q); end
   endtask

   task automatic test_abort_pause;
      send_cmd(5'd0, 5'd10, 1'b1);
      tick();
      ABORT = 1'b1;
      PAUSE = 1'b1;
      tick();
      ABORT = 1'b0;
      PAUSE = 1'b0;
      checks++; if ({ABORTED, BUSY, CMD_READY, Q} !== {3'b101, 5'd1}) begin errors++; $display("[TB] FAIL abort_wins: got %b%b%b/%0d expected 101/1", ABORTED, BUSY, CMD_READY, Q); end
      tick();
      checks++; if (ABORTED !== 1'b0) begin errors++; $display("[TB] FAIL abort_wins_pulse: got %b expected 0", ABORTED); end
   endtask

   task automatic test_reset_mid_run;
      send_cmd(5'd18, 5'd5, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      checks++; if (Q !== 5'd14) begin errors++; $display("[TB] FAIL rstmid_pre: got %0d expected 14", Q); end
      RESET = 1'b1;
      tick();
      checks++; if ({Q, UP_DOWN, BUSY, DONE, ABORTED, CMD_READY} !== {5'd0, 5'b10000}) begin errors++; $display("[TB] FAIL rstmid_state: got %0d/%b%b%b%b%b expected 0/10000", Q, UP_DOWN, BUSY, DONE, ABORTED, CMD_READY); end
      RESET = 1'b0;
      tick();
      checks++; if ({Q, DONE, ABORTED, CMD_READY} !== {5'd0, 3'b001}) begin errors++; $display("[TB] FAIL rstmid_idle: got %0d/%b%b%b expected 0/001", Q, DONE, ABORTED, CMD_READY); end
   endtask

   task automatic test_start_eq_end;
      send_cmd(5'd6, 5'd6, 1'b1);
      checks++; if ({Q, BUSY, WRAP} !== {5'd6, 2'b10}) begin errors++; $display("[TB] FAIL same_load: got %0d/%b%b expected 6/10", Q, BUSY, WRAP); end
      tick();
      checks++; if ({Q, DONE, WRAP, BUSY} !== {5'd6, 3'b100}) begin errors++; $display("[TB] FAIL same_done: got %0d/%b%b%b expected 6/100", Q, DONE, WRAP, BUSY); end
      tick();
      checks++; if ({DONE, WRAP, CMD_READY} !== 3'b001) begin errors++; $display("[TB] FAIL same_idle: got %b expected 001", {DONE, WRAP, CMD_READY}); end
   endtask

   task automatic test_back_to_back;
      CMD_VALID = 1'b1;
      CMD_START = 5'd1;
      CMD_END   = 5'd2;
      CMD_UP    = 1'b1;
      tick();
      checks++; if ({Q, BUSY} !== {5'd1, 1'b1}) begin errors++; $display("[TB] FAIL b2b_first: got %0d/%b expected 1/1", Q, BUSY); end
      CMD_START = 5'd20;
      CMD_END   = 5'd18;
      CMD_UP    = 1'b0;
      tick();
      checks++; if ({Q, UP_DOWN, CMD_READY} !== {5'd2, 2'b10}) begin errors++; $display("[TB] FAIL b2b_run: got %0d/%b%b expected 2/10", Q, UP_DOWN, CMD_READY); end
      tick();
      checks++; if ({Q, DONE, CMD_READY} !== {5'd2, 2'b10}) begin errors++; $display("[TB] FAIL b2b_finish: got %0d/%b%b expected 2/10", Q, DONE, CMD_READY); end
      tick();
      checks++; if ({Q, DONE, BUSY, CMD_READY} !== {5'd2, 3'b001}) begin errors++; $display("[TB] FAIL b2b_idle: got %0d/%b%b%b expected 2/001", Q, DONE, BUSY, CMD_READY); end
      tick();
      CMD_VALID = 1'b0;
      checks++; if ({Q, UP_DOWN, BUSY} !== {5'd20, 2'b01}) begin errors++; $display("[TB] FAIL b2b_second: got %0d/%b%b expected 20/01", Q, UP_DOWN, BUSY); end
      tick();
      tick();
      checks++; if (Q !== 5'd18) begin errors++; $display("[TB] FAIL b2b_second_q: got %0d expected 18", Q); end
      tick();
      checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_done: got %b expected 1", DONE); end
      tick();
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      RESET     = 1'b1;
      CMD_VALID = 1'b0;
      CMD_START = '0;
      CMD_END   = '0;
      CMD_UP    = 1'b0;
      PAUSE     = 1'b0;
      ABORT     = 1'b0;
      @(negedge CLK);
      test_reset();
      test_basic_up();
      test_wrap_up();
      test_wrap_down();
      test_pause();
      test_abort();
      test_abort_pause();
      test_reset_mid_run();
      test_start_eq_end();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/count_run_controller.md
Name: count_run_controller

Overview:
- Sequences a WIDTH-bit up/down counter through bounded runs.
- Accepts a run command (start value, end value, direction) over a valid/ready handshake, loads the counter, and steps it once per clock until the end value is reached.
- Signals completion, supports pause and abort, and flags modulo wrap-around.
- Sits between a command source (test sequencer / CPU shim) and the counter datapath; the counter register is owned inside this block.

Parameters:
WIDTH, 5, counter and command value width in bits (legal range 2..16)

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous, active-high reset
CMD_VALID  input  1  command present
CMD_READY  output  1  block can accept a command
CMD_START  input  WIDTH  first count value of the run
CMD_END  input  WIDTH  last count value of the run
CMD_UP  input  1  direction: 1 = up (+1), 0 = down (-1)
PAUSE  input  1  hold count while high (RUN only)
ABORT  input  1  terminate current run
Q  output  WIDTH  current count value
UP_DOWN  output  1  latched direction of current/last run
BUSY  output  1  high in LOAD-accepted RUN state
DONE  output  1  one-cycle pulse: run reached CMD_END
ABORTED  output  1  one-cycle pulse: run terminated by ABORT
WRAP  output  1  one-cycle pulse: count wrapped (2^WIDTH-1 -> 0 up, 0 -> 2^WIDTH-1 down)

Behaviour:
- States: IDLE, RUN, FINISH. All state and outputs are registered except CMD_READY.
- Reset (RESET=1 at a rising edge):
  - state=IDLE, Q=0, UP_DOWN=1, BUSY=0, DONE=0, ABORTED=0, WRAP=0, latched end=0.
  - RESET has priority over every other input, including mid-run; no DONE or ABORTED pulse results.
- CMD_READY = (state==IDLE) && !RESET. It is 0 in RUN and FINISH, so commands are never accepted there.
- IDLE:
  - Handshake when CMD_VALID && CMD_READY at an edge: Q<=CMD_START, end<=CMD_END, UP_DOWN<=CMD_UP, BUSY<=1, state<=RUN.
  - Command fields are sampled only at the handshake edge.
  - Q holds its previous value while in IDLE.
- RUN, evaluated per edge in priority order ABORT > PAUSE > compare/step:
  - ABORT=1: state<=IDLE, BUSY<=0, ABORTED<=1 for one cycle, Q holds.
  - PAUSE=1: no change. Q, state and the end comparison are all frozen.
  - Q==end: state<=FINISH, BUSY<=0, DONE<=1, Q holds at end.
  - Otherwise: Q<=Q+1 if UP_DOWN=1, else Q-1, modulo 2^WIDTH. WRAP<=1 on the edge where Q goes 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down); 0 otherwise.
- FINISH: lasts exactly one cycle with DONE=1, then state<=IDLE and DONE<=0. ABORT and PAUSE are ignored here.
- Timing:
  - A run of distance D = |steps from start to end in the commanded direction| (0..2^WIDTH-1) takes D+1 unpaused RUN edges.
  - DONE is visible 1 cycle after Q first shows end.
  - The earliest next handshake is the edge after the DONE cycle.
- start==end: D=0. The first RUN edge goes straight to FINISH, with no stepping and no WRAP.
- The run always travels the commanded direction, wrapping if needed. It never takes the shorter path.
- DONE, ABORTED and WRAP are mutually exclusive per cycle. DONE and ABORTED never both occur for one run.
- ABORT or PAUSE asserted in IDLE: no effect.

Test Plan:
- Reset, then CMD start=3 end=7 up -> Q=3,4,5,6,7 on successive cycles; BUSY=1 throughout; DONE=1 for one cycle after Q=7; CMD_READY=0 until then; Q holds 7.
- CMD start=30 end=1 up (WIDTH=5) -> Q=30,31,0,1; WRAP=1 exactly in the cycle Q=0 appears; DONE follows. Then CMD start=2 end=29 down -> Q=2,1,0,31,30,29; WRAP with Q=31; UP_DOWN=0.
- CMD start=10 end=15 up, PAUSE high 3 cycles while Q=12 -> Q stays 12 for 3 cycles, then resumes 13,14,15; DONE after 15; total run 3 cycles longer.
- CMD start=5 end=20 up, ABORT at Q=9 -> ABORTED one-cycle pulse, DONE never, BUSY=0, Q holds 9, CMD_READY=1 next cycle. Also assert ABORT and PAUSE together in RUN -> abort wins.
- RESET mid-run at Q=14 -> next cycle Q=0, state IDLE, no DONE/ABORTED. CMD start=end=6 -> Q=6, DONE one cycle later, WRAP never. CMD_VALID held high during RUN/FINISH -> no second accept until IDLE.
- Back-to-back: CMD_VALID held continuously with new fields -> second handshake exactly at the edge following the DONE cycle; a new Q=start is loaded then.
